// File: rtl/hex_display_driver.sv
// hex_display_driver: drives DIGITS active-low 7-segment+DP displays from captured hex nibbles.
// Latency: LOAD at edge k -> capture registers and LOADED at k, OUT/OVF at k+1; live inputs one edge.
// Backpressure: none; LOAD is accepted on every cycle it is high and the last capture wins.
//
// Ports:
//   CLK        system clock, all state on rising edge
//   RST_N      synchronous active-low reset
//   LOAD       capture strobe for VALUE, DP, BLINK_EN, NEG
//   VALUE      hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   DP         per-digit decimal point request (1 = lit)
//   BLINK_EN   per-digit blink enable
//   NEG        request a minus sign left of the most significant shown digit
//   LZ_EN      leading-zero blanking enable (live)
//   LAMP_TEST  force all segments lit (live)
//   OUT        byte i = digit i; bit7 DP, bits6..0 g..a; 0 = lit
//   LOADED     one-cycle capture confirmation
//   OVF        minus sign requested but no free position left of the number
module hex_display_driver #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     BLINK_EN,
  input  logic                  NEG,
  input  logic                  LZ_EN,
  input  logic                  LAMP_TEST,
  output logic [8*DIGITS-1:0]   OUT,
  output logic                  LOADED,
  output logic                  OVF
);

  localparam int             CW      = $clog2(BLINK_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BLINK_DIV - 1);

  localparam logic [7:0] GLYPH_MINUS = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_LAMP  = 8'h00;

  // Capture registers
  logic [4*DIGITS-1:0] r_val;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_blink;
  logic                r_neg;

  // Blink timebase
  logic [CW-1:0]       r_cnt;
  logic                r_phase;

  // Output registers
  logic [8*DIGITS-1:0] r_out;
  logic                r_loaded;
  logic                r_ovf;

  // Composition
  logic [8*DIGITS-1:0] w_out;
  logic                w_ovf;
  logic [DIGITS-1:0]   w_blank;
  logic                w_zero_run;
  int                  w_msd;
  logic [7:0]          w_glyph;
  logic                w_wrap;

  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  assign w_wrap = (r_cnt == CNT_MAX);

  always_comb begin
    w_out      = '1;
    w_ovf      = 1'b0;
    w_blank    = '0;
    w_zero_run = 1'b1;
    w_msd      = 0;
    w_glyph    = GLYPH_BLANK;

    // Walk down from the top: a digit is a leading zero while every nibble
    // above and including it is zero. Digit 0 always stays visible.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_val[4*i +: 4] == 4'h0);
      w_blank[i] = LZ_EN & w_zero_run & (i != 0);
    end

    // Blanked digits form a contiguous run from the top, so the last
    // unblanked index seen going upward is the most significant shown digit.
    for (int i = 0; i < DIGITS; i++) begin
      if (!w_blank[i]) w_msd = i;
    end

    w_ovf = r_neg && (w_msd == DIGITS - 1);

    for (int i = 0; i < DIGITS; i++) begin
      w_glyph = w_blank[i] ? GLYPH_BLANK : hex_glyph(r_val[4*i +: 4]);
      if (r_neg && (i == w_msd + 1)) w_glyph = GLYPH_MINUS;
      if (r_dp[i])                   w_glyph[7] = 1'b0;
      // Blink-off hides the whole digit, decimal point included.
      if (r_blink[i] && !r_phase)    w_glyph = GLYPH_BLANK;
      if (LAMP_TEST)                 w_glyph = GLYPH_LAMP;
      w_out[8*i +: 8] = w_glyph;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_val    <= '0;
      r_dp     <= '0;
      r_blink  <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_phase  <= 1'b1;
      r_out    <= '1;
      r_loaded <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (LOAD) begin
        r_val   <= VALUE;
        r_dp    <= DP;
        r_blink <= BLINK_EN;
        r_neg   <= NEG;
      end
      r_loaded <= LOAD;
      // The timebase free-runs; captures never disturb it.
      r_cnt    <= w_wrap ? '0 : r_cnt + CW'(1);
      if (w_wrap) r_phase <= ~r_phase;
      r_out    <= w_out;
      r_ovf    <= w_ovf;
    end
  end

  assign OUT    = r_out;
  assign LOADED = r_loaded;
  assign OVF    = r_ovf;

endmodule
